cache_tag_lookup: RTL and testbench

Parametrised N-way set-associative tag store and hit detector for the data-cache path in the memory stage. Holds per-set tags, valid bits and true-LRU ages. Answers registered hit/way queries and installs tags on fill, choosing the victim itself. Generalises the single-way registered hit check to configurable tag width, set count and associativity, and adds replacement and invalidation.

---
 rtl/cache_tag_lookup_if.sv | 37 +++
 rtl/cache_tag_lookup.sv | 188 ++++++++++++++++++
 tb/tb_cache_tag_lookup.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cache_tag_lookup_if.sv
// Bundles the lookup, fill and invalidate requests and the registered lookup
// response of cache_tag_lookup.
//   master : drives iLookupEn/iSet/iTag/iWriteEn, iFillEn/iFillSet/iFillTag,
//            iInvAll; receives oValid/oHit/oHitWay/oVictimWay
//   slave  : the tag store itself (mirror of master)
interface cache_tag_lookup_if #(
    parameter int TAG_W = 26,
    parameter int SET_W = 2,
    parameter int WAYS  = 2
);
    localparam int WAY_W = $clog2(WAYS);

    logic             iLookupEn;
    logic [SET_W-1:0] iSet;
    logic [TAG_W-1:0] iTag;
    logic             iWriteEn;
    logic             iFillEn;
    logic [SET_W-1:0] iFillSet;
    logic [TAG_W-1:0] iFillTag;
    logic             iInvAll;
    logic             oValid;
    logic             oHit;
    logic [WAY_W-1:0] oHitWay;
    logic [WAY_W-1:0] oVictimWay;

    modport master (
        output iLookupEn, iSet, iTag, iWriteEn,
        output iFillEn, iFillSet, iFillTag, iInvAll,
        input  oValid, oHit, oHitWay, oVictimWay
    );

    modport slave (
        input  iLookupEn, iSet, iTag, iWriteEn,
        input  iFillEn, iFillSet, iFillTag, iInvAll,
        output oValid, oHit, oHitWay, oVictimWay
    );
endinterface

// File: rtl/cache_tag_lookup.sv
// N-way set-associative tag store with registered hit detection and true-LRU
// replacement for the data-cache path.
//   iClk  : clock, rising edge
//   iRst  : asynchronous active-high reset
//   bus   : cache_tag_lookup_if.slave
//           lookup request (iLookupEn, iSet, iTag, iWriteEn) answered one
//           cycle later on oValid/oHit/oHitWay/oVictimWay;
//           fill request (iFillEn, iFillSet, iFillTag) installs into the
//           victim way chosen here; iInvAll clears every valid bit.
// Per set and way: valid bit, tag, and an age. Ages in a set are always a
// permutation of 0..WAYS-1 with 0 = most recently used.
module cache_tag_lookup #(
    parameter int TAG_W = 26,
    parameter int SET_W = 2,
    parameter int WAYS  = 2
) (
    input  logic iClk,
    input  logic iRst,
    cache_tag_lookup_if.slave bus
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 2 ** SET_W;

    typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;
    typedef logic [WAYS-1:0][TAG_W-1:0] tag_vec_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] valid_d [SETS];
    tag_vec_t        tag_q   [SETS];
    tag_vec_t        tag_d   [SETS];
    age_vec_t        age_q   [SETS];
    age_vec_t        age_d   [SETS];

    logic             out_valid_q, out_valid_d;
    logic             hit_q, hit_d;
    logic [WAY_W-1:0] hit_way_q, hit_way_d;
    logic [WAY_W-1:0] victim_way_q, victim_way_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic age_vec_t age_reset();
        age_vec_t res;
        for (int w = 0; w < WAYS; w++) begin
            res[w] = WAY_W'(w);
        end
        return res;
    endfunction

    // Promote one way to MRU; only ways younger than it age by one, so the
    // set stays a permutation.
    function automatic age_vec_t touch(age_vec_t ages, logic [WAY_W-1:0] way);
        age_vec_t res;
        res = ages;
        for (int w = 0; w < WAYS; w++) begin
            if (ages[w] < ages[way]) begin
                res[w] = ages[w] + WAY_W'(1);
            end
        end
        res[way] = '0;
        return res;
    endfunction

    // Lowest invalid way wins; with a full set, the LRU way (oldest age).
    function automatic logic [WAY_W-1:0] victim(logic [WAYS-1:0] valid, age_vec_t ages);
        logic [WAY_W-1:0] res;
        logic             found;
        res   = '0;
        found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[w] && !found) begin
                res   = WAY_W'(w);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ages[w] == WAY_W'(WAYS - 1)) begin
                    res = WAY_W'(w);
                end
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Lookup evaluation (always on pre-edge state)
    // ------------------------------------------------------------------
    logic [WAYS-1:0]  match;
    logic [WAY_W-1:0] match_way;
    logic             lookup_hit;
    logic [WAY_W-1:0] lookup_victim;
    logic [WAY_W-1:0] fill_victim;
    logic             fill_same_set;

    always_comb begin
        match     = '0;
        match_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_q[bus.iSet][w] && (tag_q[bus.iSet][w] == bus.iTag);
        end
        // Descending scan so the lowest matching way is the one kept.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                match_way = WAY_W'(w);
            end
        end
        lookup_hit    = bus.iLookupEn && (|match) && !bus.iWriteEn;
        lookup_victim = victim(valid_q[bus.iSet], age_q[bus.iSet]);
        fill_victim   = victim(valid_q[bus.iFillSet], age_q[bus.iFillSet]);
        fill_same_set = bus.iFillEn && (bus.iFillSet == bus.iSet);
    end

    // ------------------------------------------------------------------
    // Tag/valid/age update: invalidate > fill > lookup touch
    // ------------------------------------------------------------------
    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            valid_d[s] = valid_q[s];
            tag_d[s]   = tag_q[s];
            age_d[s]   = age_q[s];
        end

        if (bus.iInvAll) begin
            for (int s = 0; s < SETS; s++) begin
                valid_d[s] = '0;
                age_d[s]   = age_reset();
            end
        end else begin
            if (bus.iFillEn) begin
                tag_d[bus.iFillSet][fill_victim]   = bus.iFillTag;
                valid_d[bus.iFillSet][fill_victim] = 1'b1;
                age_d[bus.iFillSet] = touch(age_q[bus.iFillSet], fill_victim);
            end
            // A fill into the same set owns that set's age update this edge.
            if (lookup_hit && !fill_same_set) begin
                age_d[bus.iSet] = touch(age_q[bus.iSet], match_way);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response register; way fields hold while idle
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d  = bus.iLookupEn;
        hit_d        = lookup_hit;
        hit_way_d    = hit_way_q;
        victim_way_d = victim_way_q;
        if (bus.iLookupEn) begin
            hit_way_d    = lookup_hit ? match_way : '0;
            victim_way_d = lookup_victim;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                tag_q[s]   <= '0;
                age_q[s]   <= age_reset();
            end
            out_valid_q  <= 1'b0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            victim_way_q <= '0;
        end else begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= valid_d[s];
                tag_q[s]   <= tag_d[s];
                age_q[s]   <= age_d[s];
            end
            out_valid_q  <= out_valid_d;
            hit_q        <= hit_d;
            hit_way_q    <= hit_way_d;
            victim_way_q <= victim_way_d;
        end
    end

    assign bus.oValid     = out_valid_q;
    assign bus.oHit       = hit_q;
    assign bus.oHitWay    = hit_way_q;
    assign bus.oVictimWay = victim_way_q;

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed bench for cache_tag_lookup (2 ways, 4 sets, 26-bit tags).
// Each lookup pushes its hand-derived expected response; the response is
// popped and compared one cycle later.
module tb_cache_tag_lookup;
    localparam int TAG_W = 26;
    localparam int SET_W = 2;
    localparam int WAYS  = 2;
    localparam int WAY_W = 1;

    logic iClk = 1'b0;
    logic iRst;

    always #5 iClk = ~iClk;

    cache_tag_lookup_if #(.TAG_W(TAG_W), .SET_W(SET_W), .WAYS(WAYS)) bus ();

    cache_tag_lookup #(.TAG_W(TAG_W), .SET_W(SET_W), .WAYS(WAYS)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    typedef struct packed {
        logic             hit;
        logic [WAY_W-1:0] way;
        logic [WAY_W-1:0] vic;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_assert = 0;
    int    n_fail   = 0;
    logic [WAY_W-1:0] last_way = '0;
    logic [WAY_W-1:0] last_vic = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, expv);
            $error("check %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle_all();
        bus.iLookupEn = 1'b0;
        bus.iWriteEn  = 1'b0;
        bus.iFillEn   = 1'b0;
        bus.iInvAll   = 1'b0;
    endtask

    task automatic lookup(input logic [SET_W-1:0] set, input logic [TAG_W-1:0] tag,
                          input logic we, input logic hit, input logic [WAY_W-1:0] way,
                          input logic [WAY_W-1:0] vic, input string name);
        exp_t e;
        bus.iLookupEn = 1'b1;
        bus.iSet      = set;
        bus.iTag      = tag;
        bus.iWriteEn  = we;
        e.hit = hit;
        e.way = way;
        e.vic = vic;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic fill(input logic [SET_W-1:0] set, input logic [TAG_W-1:0] tag);
        bus.iFillEn  = 1'b1;
        bus.iFillSet = set;
        bus.iFillTag = tag;
    endtask

    // One clock: sample just after the edge, compare, then drop requests.
    task automatic step();
        exp_t  e;
        string nm;
        @(posedge iClk);
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk({nm, ".valid"},  32'(bus.oValid),     32'd1);
            chk({nm, ".hit"},    32'(bus.oHit),       32'(e.hit));
            chk({nm, ".hitway"}, 32'(bus.oHitWay),    32'(e.way));
            chk({nm, ".victim"}, 32'(bus.oVictimWay), 32'(e.vic));
            last_way = e.way;
            last_vic = e.vic;
        end else begin
            chk("idle.valid",  32'(bus.oValid),     32'd0);
            chk("idle.hit",    32'(bus.oHit),       32'd0);
            chk("idle.hitway", 32'(bus.oHitWay),    32'(last_way));
            chk("idle.victim", 32'(bus.oVictimWay), 32'(last_vic));
        end
        idle_all();
    endtask

    initial begin
        idle_all();
        bus.iSet     = '0;
        bus.iTag     = '0;
        bus.iFillSet = '0;
        bus.iFillTag = '0;
        iRst = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;

        chk("reset.valid",  32'(bus.oValid),     32'd0);
        chk("reset.hit",    32'(bus.oHit),       32'd0);
        chk("reset.hitway", 32'(bus.oHitWay),    32'd0);
        chk("reset.victim", 32'(bus.oVictimWay), 32'd0);

        lookup(2'd0, 26'h123, 1'b0, 1'b0, 1'b0, 1'b0, "miss_empty");              step();

        fill(2'd1, 26'h0ABCDEF);                                                  step();
        lookup(2'd1, 26'h0ABCDEF, 1'b0, 1'b1, 1'b0, 1'b1, "hit_set1");            step();
        lookup(2'd1, 26'h0ABCDEF, 1'b1, 1'b0, 1'b0, 1'b1, "store_miss");          step();

        // Set 2 replacement: A->way0, B->way1, hit A, C evicts B (way1)
        fill(2'd2, 26'h111);                                                      step();
        fill(2'd2, 26'h222);                                                      step();
        lookup(2'd2, 26'h111, 1'b0, 1'b1, 1'b0, 1'b0, "hit_A");                   step();
        fill(2'd2, 26'h333);                                                      step();
        lookup(2'd2, 26'h222, 1'b0, 1'b0, 1'b0, 1'b0, "evicted_B");               step();
        lookup(2'd2, 26'h333, 1'b0, 1'b1, 1'b1, 1'b0, "hit_C");                   step();
        step();

        // Same-set fill + hit: fill evicts way0 and its touch wins over C's
        fill(2'd2, 26'h777);
        lookup(2'd2, 26'h333, 1'b0, 1'b1, 1'b1, 1'b0, "fill_hit_same_set");       step();
        lookup(2'd2, 26'h777, 1'b0, 1'b1, 1'b0, 1'b1, "hit_E");                   step();
        lookup(2'd2, 26'h111, 1'b0, 1'b0, 1'b0, 1'b1, "evicted_A");               step();
        step();

        // Same-cycle fill and lookup: lookup sees pre-edge state
        fill(2'd3, 26'h444);
        lookup(2'd3, 26'h444, 1'b0, 1'b0, 1'b0, 1'b0, "same_cycle_fill");         step();
        lookup(2'd3, 26'h444, 1'b0, 1'b1, 1'b0, 1'b1, "after_fill");              step();

        // Different-set fill alongside a hit: both apply
        fill(2'd0, 26'h555);
        lookup(2'd3, 26'h444, 1'b0, 1'b1, 1'b0, 1'b1, "diff_set_fill");           step();
        lookup(2'd0, 26'h555, 1'b0, 1'b1, 1'b0, 1'b1, "hit_set0");                step();

        // Invalidate all; the same-cycle fill is dropped
        bus.iInvAll = 1'b1;
        fill(2'd0, 26'h666);                                                      step();
        lookup(2'd0, 26'h555,     1'b0, 1'b0, 1'b0, 1'b0, "inv_set0");            step();
        lookup(2'd1, 26'h0ABCDEF, 1'b0, 1'b0, 1'b0, 1'b0, "inv_set1");            step();
        lookup(2'd2, 26'h333,     1'b0, 1'b0, 1'b0, 1'b0, "inv_set2_c");          step();
        lookup(2'd2, 26'h777,     1'b0, 1'b0, 1'b0, 1'b0, "inv_set2_e");          step();
        lookup(2'd3, 26'h444,     1'b0, 1'b0, 1'b0, 1'b0, "inv_set3");            step();
        lookup(2'd0, 26'h666,     1'b0, 1'b0, 1'b0, 1'b0, "inv_dropped_fill");    step();

        // Asynchronous reset between a lookup edge and the sampling point
        fill(2'd1, 26'h0ABCDEF);                                                  step();
        bus.iLookupEn = 1'b1;
        bus.iSet      = 2'd1;
        bus.iTag      = 26'h0ABCDEF;
        bus.iWriteEn  = 1'b0;
        @(posedge iClk);
        #1;
        chk("prerst.valid",  32'(bus.oValid),     32'd1);
        chk("prerst.hit",    32'(bus.oHit),       32'd1);
        chk("prerst.victim", 32'(bus.oVictimWay), 32'd1);
        idle_all();
        iRst = 1'b1;
        #1;
        chk("async_rst.valid",  32'(bus.oValid),     32'd0);
        chk("async_rst.hit",    32'(bus.oHit),       32'd0);
        chk("async_rst.hitway", 32'(bus.oHitWay),    32'd0);
        chk("async_rst.victim", 32'(bus.oVictimWay), 32'd0);
        #1;
        iRst = 1'b0;
        last_way = '0;
        last_vic = '0;
        lookup(2'd1, 26'h0ABCDEF, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset_miss");    step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
